fifo_tx: RTL and testbench
==========================

# fifo_tx

Transmit engine for the FTDI asynchronous 245 FIFO: buffers bytes from internal logic and writes them to the host over the shared `fifo_d` bus using `fifo_wr_n`, throttled by `fifo_txe_n`. It is the FPGA-to-host counterpart of the FIFO receive path and sits between internal producers and the `pin_bidir_8` on `fifo_d`. Bus ownership is negotiated with the receive side through a request/grant pair.

## Interface
Parameters:
- `DEPTH`, 16: byte buffer entries; power of two, at least 2.
- `TXE_BLANK`, 3: cycles after each write during which `fifo_txe_n` is ignored. Covers synchronizer latency plus the FTDI TXE# deassert delay.
- `SIWU_IDLE`, 8: empty-buffer cycles before a send-immediate pulse. Only used with `FIFO_TX_SIWU_EN`.

Ports (one clock; reset is asynchronous and active-high):
- `clk_12mhz`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `in_data`  in  8  byte to send.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  buffer can accept; a transfer occurs when `in_valid & in_ready`.
- `level`  out  $clog2(DEPTH+1)  bytes currently buffered.
- `fifo_txe_n`  in  1  FTDI TX-space flag, asynchronous, active-low.
- `d_out`  out  8  data to the pad.
- `d_dir`  out  1  1 = FPGA drives `fifo_d`.
- `wr_n`  out  1  FTDI WR#, active-low.
- `siwu`  out  1  FTDI SIWU#, active-low.
- `bus_req`  out  1  request for ownership of `fifo_d`.
- `bus_gnt`  in  1  ownership granted.
- `busy`  out  1  FSM not in IDLE.

## Operation
- `fifo_txe_n` passes through a 2-flop synchronizer (`txe_s`); both flops reset to 1.
- Blank counter: loaded with `TXE_BLANK` on leaving HOLD, decrements to 0. TX is allowed when `txe_s==0` and the counter is 0.
- FSM states:
  - IDLE: if buffer is not empty and TX is allowed, go to REQ.
  - REQ: `bus_req=1`; when `bus_gnt` is sampled high, go to SETUP.
  - SETUP: `d_dir=1`, `d_out` = buffer head. Lasts 1 cycle.
  - STROBE: `wr_n=0`, data held. Lasts 1 cycle.
  - HOLD: `wr_n=1`, data held, buffer popped at the end. Lasts 1 cycle, then IDLE.
- `bus_req` and `d_dir` are high in REQ through HOLD and low in IDLE (1 cycle bus turnaround).
- Once in SETUP, `bus_gnt` is ignored. The arbiter never revokes a grant while `bus_req` is high.
- All outputs are registered, decoded from the next state.
- Buffer behaviour:
  - Push and pop in the same cycle: `level` is unchanged.
  - Full: `in_ready=0`; no overwrite.
  - Empty: no REQ.
  - Pointers wrap modulo DEPTH.
- `txe_s` rising mid-transaction does not abort it; the next byte waits in IDLE.
- Reset values:
  - Outputs: `wr_n=1`, `siwu=1`, `d_dir=0`, `d_out=0`, `bus_req=0`, `busy=0`, `level=0`, `in_ready=0`.
  - `in_ready` goes to 1 on the first clock after `rst` falls.
  - Buffer is emptied and blank counter is set to 0.
- Reset mid-transaction forces `wr_n=1` and `d_dir=0` immediately. Whether the host received that byte is undefined.

## Timing
- Accept at cycle N into an empty buffer, with TX allowed and `bus_gnt` high from N+1:
  - REQ at N+1, SETUP at N+2.
  - `wr_n` low during N+3, HOLD at N+4, IDLE at N+5.
- Minimum byte period is 5 cycles plus `TXE_BLANK` (8 cycles at defaults, about 667 ns).
- FTDI timing at 12 MHz: data setup before WR# fall is at least 83 ns, WR# low width 83 ns, data hold after WR# rise 83 ns.
- `level` updates the cycle after the push or pop.

## Configuration
- With `FIFO_TX_SIWU_EN` defined: after at least one byte is written, when the buffer has stayed empty and IDLE for `SIWU_IDLE` consecutive cycles, `siwu` goes low for exactly 1 cycle.
  - Re-armed only by a subsequent write.
  - A push during the count cancels it.
- Without it: `siwu` is constant 1, and there is no counter or arm logic.

## Structure
- Shared package `fifo_pkg`:
  - TX FSM state encoding (IDLE, REQ, SETUP, STROBE, HOLD).
  - `LVL_DIR_INPUT`/`LVL_DIR_OUTPUT` constants.
  - Default `TXE_BLANK`.
- One sub-module, `byte_fifo`: DEPTH x 8 synchronous FIFO with push/pop/full/empty/level, async reset, and first-word fall-through head.

## Test plan
- Single byte 0xA5, `txe_n=0`, `bus_gnt` tied high: `wr_n` low exactly 1 cycle, 3 cycles after accept; `d_out=0xA5` from SETUP through HOLD; `level` goes 1 then 0.
- Push 16 bytes 0x00..0x0F with `txe_n=1`: `in_ready` falls after the 16th; no `wr_n` pulses. Release `txe_n`: 16 pulses in order, spaced 8 cycles apart.
- Hold `bus_gnt` low for 10 cycles with data pending: stays in REQ, `d_dir=0`, `wr_n=1`. Grant: write completes 3 cycles later.
- Toggle `txe_n` high during STROBE: current byte completes; next byte waits until `txe_n` is low and blanking has expired.
- Assert `rst` during STROBE: `wr_n=1`, `d_dir=0`, `bus_req=0` immediately; `level=0` after release.
- With `FIFO_TX_SIWU_EN`: write 2 bytes, then idle: `siwu` low for one cycle exactly 8 cycles after the buffer empties, and no second pulse.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FTDI async-245 FIFO transmit path: TX FSM encoding,
// level-shifter direction constants and the default TXE# blanking length.
package fifo_pkg;
   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_REQ    = 3'd1,
      TX_SETUP  = 3'd2,
      TX_STROBE = 3'd3,
      TX_HOLD   = 3'd4
   } tx_state_t;

   localparam logic LVL_DIR_INPUT  = 1'b0;
   localparam logic LVL_DIR_OUTPUT = 1'b1;

   localparam int TXE_BLANK_DEFAULT = 3;
endpackage

// File: rtl/fifo_tx_if.sv
// Producer-side byte stream into fifo_tx: valid/ready handshake plus fill level.
interface fifo_tx_if #(parameter int DEPTH = 16);
   localparam int LW = $clog2(DEPTH + 1);

   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [LW-1:0] level;

   modport master (output in_data, output in_valid, input in_ready, input level);
   modport slave  (input in_data, input in_valid, output in_ready, output level);
endinterface

// File: rtl/byte_fifo.sv
// DEPTH x 8 synchronous FIFO with first-word fall-through head and occupancy count.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [7:0]                   wdata,
   input  logic                         pop,
   output logic [7:0]                   head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [LW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full      = (count_r == LW'(DEPTH));
   assign empty     = (count_r == {LW{1'b0}});
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign head      = mem_r[rd_ptr_r];
   assign level     = count_r;

   // Storage array; contents are only meaningful between the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata;
      end
   end

   // Pointer and occupancy bookkeeping; power-of-two DEPTH lets pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {LW{1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + LW'(1);
            2'b01:   count_r <= count_r - LW'(1);
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: rtl/fifo_tx.sv
// FTDI async-245 FIFO transmit engine: buffers bytes and strobes them out with WR#.
// Optional send-immediate (SIWU#) pulse after idling is enabled by FIFO_TX_SIWU_EN.
module fifo_tx import fifo_pkg::*; #(
   parameter int DEPTH     = 16,
   parameter int TXE_BLANK = TXE_BLANK_DEFAULT,
   parameter int SIWU_IDLE = 8
) (
   input  logic       clk_12mhz,
   input  logic       rst,
   fifo_tx_if.slave   in_if,
   input  logic       fifo_txe_n,
   output logic [7:0] d_out,
   output logic       d_dir,
   output logic       wr_n,
   output logic       siwu,
   output logic       bus_req,
   input  logic       bus_gnt,
   output logic       busy
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int BW = (TXE_BLANK > 0) ? $clog2(TXE_BLANK + 1) : 1;

   tx_state_t     state_r, state_nx_s;
   logic          txe_meta_r, txe_s;
   logic [BW-1:0] blank_r;
   logic          tx_ok_s, push_s, pop_s, empty_s, full_s, in_ready_r;
   logic [7:0]    head_s;
   logic [LW-1:0] level_s, level_nx_s;
   logic [7:0]    d_out_r;
   logic          d_dir_r, wr_n_r, bus_req_r, busy_r;

   assign push_s  = in_if.in_valid & in_ready_r;
   assign pop_s   = (state_r == TX_HOLD);
   assign tx_ok_s = ~txe_s & (blank_r == {BW{1'b0}});

   byte_fifo #(.DEPTH(DEPTH)) u_buf (
      .clk   (clk_12mhz),
      .rst   (rst),
      .push  (push_s),
      .wdata (in_if.in_data),
      .pop   (pop_s),
      .head  (head_s),
      .full  (full_s),
      .empty (empty_s),
      .level (level_s)
   );

   // TXE# synchronizer and post-write blanking, since TXE# lags each WR# strobe.
   always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
         txe_meta_r <= 1'b1;
         txe_s      <= 1'b1;
         blank_r    <= {BW{1'b0}};
      end else begin
         txe_meta_r <= fifo_txe_n;
         txe_s      <= txe_meta_r;
         if (state_r == TX_HOLD) begin
            blank_r <= BW'(TXE_BLANK);
         end else if (blank_r != {BW{1'b0}}) begin
            blank_r <= blank_r - BW'(1);
         end else begin
            blank_r <= blank_r;
         end
      end
   end

   // Occupancy one cycle ahead, so in_ready can be registered yet still stop at full.
   always_comb begin
      level_nx_s = level_s;
      case ({push_s, pop_s})
         2'b10:   level_nx_s = level_s + LW'(1);
         2'b01:   level_nx_s = level_s - LW'(1);
         default: level_nx_s = level_s;
      endcase
   end

   // Next-state logic; a push into an empty buffer starts the request the same cycle.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         TX_IDLE: begin
            if ((~empty_s | push_s) & tx_ok_s) state_nx_s = TX_REQ;
            else                               state_nx_s = TX_IDLE;
         end
         TX_REQ: begin
            if (bus_gnt) state_nx_s = TX_SETUP;
            else         state_nx_s = TX_REQ;
         end
         TX_SETUP:  state_nx_s = TX_STROBE;
         TX_STROBE: state_nx_s = TX_HOLD;
         TX_HOLD:   state_nx_s = TX_IDLE;
         default:   state_nx_s = TX_IDLE;
      endcase
   end

   // State register and outputs registered from the decoded next state.
   always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
         state_r    <= TX_IDLE;
         bus_req_r  <= 1'b0;
         busy_r     <= 1'b0;
         d_dir_r    <= LVL_DIR_INPUT;
         wr_n_r     <= 1'b1;
         d_out_r    <= 8'h00;
         in_ready_r <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         bus_req_r  <= (state_nx_s != TX_IDLE);
         busy_r     <= (state_nx_s != TX_IDLE);
         // Pads drive only once the grant has been taken (SETUP onward).
         d_dir_r    <= (state_nx_s == TX_SETUP || state_nx_s == TX_STROBE ||
                        state_nx_s == TX_HOLD) ? LVL_DIR_OUTPUT : LVL_DIR_INPUT;
         wr_n_r     <= (state_nx_s != TX_STROBE);
         d_out_r    <= (state_nx_s == TX_SETUP) ? head_s : d_out_r;
         in_ready_r <= (level_nx_s != LW'(DEPTH));
      end
   end

`ifdef FIFO_TX_SIWU_EN
   localparam int SW = $clog2(SIWU_IDLE + 1);
   logic [SW-1:0] idle_cnt_r;
   logic          armed_r;
   logic          siwu_r;

   // Idle timer: armed by each completed write, fires once, a push restarts the count.
   always_ff @(posedge clk_12mhz or posedge rst) begin
      if (rst) begin
         idle_cnt_r <= {SW{1'b0}};
         armed_r    <= 1'b0;
         siwu_r     <= 1'b1;
      end else begin
         siwu_r <= 1'b1;
         if (pop_s) begin
            armed_r    <= 1'b1;
            idle_cnt_r <= {SW{1'b0}};
         end else if (push_s) begin
            idle_cnt_r <= {SW{1'b0}};
         end else if (armed_r && empty_s && state_r == TX_IDLE) begin
            if (idle_cnt_r == SW'(SIWU_IDLE - 1)) begin
               siwu_r     <= 1'b0;
               armed_r    <= 1'b0;
               idle_cnt_r <= {SW{1'b0}};
            end else begin
               idle_cnt_r <= idle_cnt_r + SW'(1);
            end
         end else begin
            idle_cnt_r <= {SW{1'b0}};
         end
      end
   end

   assign siwu = siwu_r;
`else
   assign siwu = 1'b1;
`endif

   assign in_if.in_ready = in_ready_r;
   assign in_if.level    = level_s;
   assign d_out          = d_out_r;
   assign d_dir          = d_dir_r;
   assign wr_n           = wr_n_r;
   assign bus_req        = bus_req_r;
   assign busy           = busy_r;
endmodule

// File: tb/tb_fifo_tx.sv
// Directed bench for fifo_tx: single write timing, fill/drain ordering and spacing,
// grant stall, TXE# during strobe, reset mid-write, and optional SIWU# pulse.
module tb_fifo_tx;
   logic       clk_12mhz  = 1'b0;
   logic       rst        = 1'b1;
   logic       fifo_txe_n = 1'b0;
   logic       bus_gnt    = 1'b1;
   logic [7:0] d_out;
   logic       d_dir, wr_n, siwu, bus_req, busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic [7:0] pulse_d [$];
   int         pulse_c [$];

   fifo_tx_if #(.DEPTH(16)) in_if ();

   fifo_tx #(.DEPTH(16), .TXE_BLANK(3), .SIWU_IDLE(8)) dut (
      .clk_12mhz  (clk_12mhz),
      .rst        (rst),
      .in_if      (in_if),
      .fifo_txe_n (fifo_txe_n),
      .d_out      (d_out),
      .d_dir      (d_dir),
      .wr_n       (wr_n),
      .siwu       (siwu),
      .bus_req    (bus_req),
      .bus_gnt    (bus_gnt),
      .busy       (busy)
   );

   always #5 clk_12mhz = ~clk_12mhz;

   // Cycle counter and WR# strobe recorder, sampled mid-cycle.
   always @(posedge clk_12mhz) cyc <= cyc + 1;
   always @(negedge clk_12mhz) begin
      if (wr_n === 1'b0) begin
         pulse_d.push_back(d_out);
         pulse_c.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_12mhz);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      in_if.in_valid = 1'b0;
      in_if.in_data  = 8'h00;

      // Reset values
      step(); step();
      chk("rst_wr_n", wr_n, 1); chk("rst_siwu", siwu, 1); chk("rst_d_dir", d_dir, 0);
      chk("rst_d_out", d_out, 0); chk("rst_bus_req", bus_req, 0); chk("rst_busy", busy, 0);
      chk("rst_level", in_if.level, 0); chk("rst_in_ready", in_if.in_ready, 0);
      rst = 1'b0;
      step();
      chk("ready_after_rst", in_if.in_ready, 1);
      step(); step();

      // Single byte 0xA5, accept at N
      in_if.in_valid = 1'b1; in_if.in_data = 8'hA5;
      step(); in_if.in_valid = 1'b0;
      chk("t1_req_bus_req", bus_req, 1); chk("t1_req_d_dir", d_dir, 0);
      chk("t1_req_wr_n", wr_n, 1); chk("t1_level1", in_if.level, 1);
      step();
      chk("t1_setup_d_dir", d_dir, 1); chk("t1_setup_d_out", d_out, 8'hA5); chk("t1_setup_wr_n", wr_n, 1);
      step();
      chk("t1_strobe_wr_n", wr_n, 0); chk("t1_strobe_d_out", d_out, 8'hA5);
      step();
      chk("t1_hold_wr_n", wr_n, 1); chk("t1_hold_d_out", d_out, 8'hA5); chk("t1_hold_d_dir", d_dir, 1);
      step();
      chk("t1_idle_busy", busy, 0); chk("t1_idle_bus_req", bus_req, 0);
      chk("t1_idle_d_dir", d_dir, 0); chk("t1_level0", in_if.level, 0);

      // Fill 16 bytes with TXE# high, then drain
      pulse_d.delete(); pulse_c.delete();
      fifo_txe_n = 1'b1;
      step(); step(); step();
      for (int i = 0; i < 16; i++) begin
         in_if.in_valid = 1'b1; in_if.in_data = 8'(i);
         if (i == 15) chk("t2_ready_before_last", in_if.in_ready, 1);
         step();
      end
      in_if.in_valid = 1'b0;
      chk("t2_full_ready", in_if.in_ready, 0); chk("t2_full_level", in_if.level, 16);
      in_if.in_valid = 1'b1; in_if.in_data = 8'hEE;
      step(); step();
      in_if.in_valid = 1'b0;
      chk("t2_no_overwrite_level", in_if.level, 16);
      chk("t2_no_pulses", pulse_d.size(), 0);
      fifo_txe_n = 1'b0;
      n = 0;
      while (pulse_d.size() < 16 && n < 300) begin step(); n++; end
      for (int k = 0; k < 20; k++) step();
      chk("t2_pulse_count", pulse_d.size(), 16);
      for (int i = 0; i < 16 && i < pulse_d.size(); i++) begin
         chk($sformatf("t2_data_%0d", i), pulse_d[i], 8'(i));
         if (i > 0) chk($sformatf("t2_spacing_%0d", i), pulse_c[i] - pulse_c[i-1], 8);
      end
      chk("t2_drain_level", in_if.level, 0); chk("t2_drain_ready", in_if.in_ready, 1);

      // Grant withheld for 10 cycles
      bus_gnt = 1'b0;
      in_if.in_valid = 1'b1; in_if.in_data = 8'h3C;
      step(); in_if.in_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk("t3_stall_bus_req", bus_req, 1); chk("t3_stall_d_dir", d_dir, 0);
         chk("t3_stall_wr_n", wr_n, 1); chk("t3_stall_busy", busy, 1);
         step();
      end
      bus_gnt = 1'b1;
      step();
      chk("t3_setup_d_dir", d_dir, 1); chk("t3_setup_d_out", d_out, 8'h3C);
      step();
      chk("t3_strobe_wr_n", wr_n, 0);
      step();
      chk("t3_hold_wr_n", wr_n, 1);
      step();
      chk("t3_idle_busy", busy, 0); chk("t3_level0", in_if.level, 0);

      // TXE# rises during STROBE
      for (int k = 0; k < 5; k++) step();
      in_if.in_valid = 1'b1; in_if.in_data = 8'h11;
      step(); in_if.in_data = 8'h22;
      step(); in_if.in_valid = 1'b0;
      chk("t4_setup_d_out", d_out, 8'h11);
      step();
      chk("t4_strobe_wr_n", wr_n, 0);
      fifo_txe_n = 1'b1;
      step();
      chk("t4_hold_wr_n", wr_n, 1); chk("t4_hold_d_out", d_out, 8'h11);
      step();
      chk("t4_idle_busy", busy, 0); chk("t4_level1", in_if.level, 1);
      for (int k = 0; k < 10; k++) begin
         step();
         chk("t4_wait_busy", busy, 0);
      end
      fifo_txe_n = 1'b0;
      step(); chk("t4_sync1_busy", busy, 0);
      step(); chk("t4_sync2_busy", busy, 0);
      step(); chk("t4_req_bus_req", bus_req, 1);
      step();
      step(); chk("t4_strobe2_wr_n", wr_n, 0); chk("t4_strobe2_d_out", d_out, 8'h22);
      step(); step();
      chk("t4_level0", in_if.level, 0);

      // Reset during STROBE
      for (int k = 0; k < 5; k++) step();
      in_if.in_valid = 1'b1; in_if.in_data = 8'h77;
      step(); in_if.in_data = 8'h88;
      step(); in_if.in_valid = 1'b0;
      step();
      chk("t5_strobe_wr_n", wr_n, 0);
      rst = 1'b1;
      #1;
      chk("t5_rst_wr_n", wr_n, 1); chk("t5_rst_d_dir", d_dir, 0); chk("t5_rst_bus_req", bus_req, 0);
      chk("t5_rst_busy", busy, 0); chk("t5_rst_level", in_if.level, 0); chk("t5_rst_ready", in_if.in_ready, 0);
      step(); step();
      rst = 1'b0;
      step();
      chk("t5_rel_level", in_if.level, 0); chk("t5_rel_ready", in_if.in_ready, 1); chk("t5_rel_busy", busy, 0);

`ifdef FIFO_TX_SIWU_EN
      // SIWU# after two bytes then idle
      step(); step(); step();
      in_if.in_valid = 1'b1; in_if.in_data = 8'h01;
      step(); in_if.in_data = 8'h02;
      step(); in_if.in_valid = 1'b0;
      n = 0;
      while (in_if.level != 0 && n < 60) begin step(); n++; end
      chk("t6_empty_reached", in_if.level, 0);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t6_siwu_high_%0d", k), siwu, 1);
         step();
      end
      chk("t6_siwu_pulse", siwu, 0);
      for (int k = 0; k < 30; k++) begin
         step();
         chk("t6_siwu_no_second", siwu, 1);
      end
`else
      for (int k = 0; k < 20; k++) step();
      chk("t6_siwu_const", siwu, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
